// File: rtl/mmm_serial_datapath.sv
// Bit-serial Montgomery multiplier: P = A*B*2^-WIDTH mod M, one bit of A per enabled edge,
// followed by one conditional-subtraction edge before the result is presented.
module mmm_serial_datapath #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             ena,
   input  logic             clear,
   input  logic             ld_a,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [WIDTH-1:0] m_in,
   output logic [WIDTH-1:0] p_out,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ITER  = 2'd1,
      S_FINAL = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] p_q, p_d;

   logic             q_bit;
   logic [WIDTH+1:0] sum;
   logic             sum_lsb_unused;
   logic             acc_ge_m;
   logic [WIDTH-1:0] acc_minus_m;

   // acc < 2M keeps the pre-shift sum inside WIDTH+2 bits; q_bit forces its LSB to zero.
   always_comb begin
      q_bit       = acc_q[0] ^ (a_sh_q[0] & b_q[0]);
      sum         = {1'b0, acc_q}
                  + (a_sh_q[0] ? {2'b00, b_q} : '0)
                  + (q_bit     ? {2'b00, m_q} : '0);
      acc_ge_m    = (acc_q >= {1'b0, m_q});
      acc_minus_m = acc_q[WIDTH-1:0] - m_q;
   end

   assign sum_lsb_unused = sum[0];

   // State register; ena=0 freezes everything except reset.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         a_sh_q  <= '0;
         b_q     <= '0;
         m_q     <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
      end else if (ena) begin
         state_q <= state_d;
         acc_q   <= acc_d;
         a_sh_q  <= a_sh_d;
         b_q     <= b_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (!clear) begin
         state_d = S_IDLE;
      end else if (ld_a) begin
         state_d = S_ITER;
      end else begin
         case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_ITER:  state_d = (cnt_q == CW'(WIDTH - 1)) ? S_FINAL : S_ITER;
            S_FINAL: state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Datapath next-state, sharing the command priority of the FSM
   always_comb begin
      acc_d  = acc_q;
      a_sh_d = a_sh_q;
      b_d    = b_q;
      m_d    = m_q;
      cnt_d  = cnt_q;
      p_d    = p_q;
      if (!clear) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (ld_a) begin
         a_sh_d = a_in;
         b_d    = b_in;
         m_d    = m_in;
         acc_d  = '0;
         cnt_d  = '0;
      end else begin
         case (state_q)
            S_ITER: begin
               acc_d  = sum[WIDTH+1:1];
               a_sh_d = a_sh_q >> 1;
               cnt_d  = cnt_q + 1'b1;
            end
            S_FINAL: p_d = acc_ge_m ? acc_minus_m : acc_q[WIDTH-1:0];
            default: ;
         endcase
      end
   end

   // Outputs
   always_comb begin
      busy  = (state_q == S_ITER) || (state_q == S_FINAL);
      done  = (state_q == S_DONE);
      p_out = p_q;
   end

endmodule
